decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/dlx_pkg.sv | 62 ++++++
 rtl/decode_stage_if.sv | 30 +++
 rtl/hazard_detect.sv | 23 ++
 rtl/decode_stage.sv | 122 ++++++++++++
 tb/tb_decode_stage.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/dlx_pkg.sv
// Shared DLX decode definitions: opselect encodings, instruction field layout
// and the packing of the execute-stage control word.
package dlx_pkg;

  localparam logic [2:0] OP_SHIFT_REG   = 3'b000;
  localparam logic [2:0] OP_ARITH_LOGIC = 3'b001;
  localparam logic [2:0] OP_MEM_READ    = 3'b101;

  localparam int OPSEL_MSB   = 31;
  localparam int OPSEL_LSB   = 29;
  localparam int IMM_SEL_BIT = 28;
  localparam int OPER_MSB    = 27;
  localparam int OPER_LSB    = 25;
  localparam int DEST_MSB    = 24;
  localparam int DEST_LSB    = 21;
  localparam int SRC1_MSB    = 20;
  localparam int SRC1_LSB    = 17;
  localparam int SRC2_MSB    = 16;
  localparam int SRC2_LSB    = 13;
  localparam int IMM13_MSB   = 12;

  typedef struct packed {
    logic [2:0]  opselect;
    logic        imm_sel;
    logic [2:0]  operation;
    logic [3:0]  dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic [12:0] imm13;
  } instr_t;

  function automatic instr_t decode_fields(input logic [31:0] raw);
    instr_t f;
    f.opselect  = raw[OPSEL_MSB:OPSEL_LSB];
    f.imm_sel   = raw[IMM_SEL_BIT];
    f.operation = raw[OPER_MSB:OPER_LSB];
    f.dest      = raw[DEST_MSB:DEST_LSB];
    f.src1      = raw[SRC1_MSB:SRC1_LSB];
    f.src2      = raw[SRC2_MSB:SRC2_LSB];
    f.imm13     = raw[IMM13_MSB:0];
    return f;
  endfunction

  function automatic logic is_legal(input logic [2:0] opselect);
    return (opselect == OP_SHIFT_REG) || (opselect == OP_ARITH_LOGIC) ||
           (opselect == OP_MEM_READ);
  endfunction

  // MEM_READ doubles as load (imm_sel=0) and store (imm_sel=1).
  function automatic logic is_load(input instr_t i);
    return (i.opselect == OP_MEM_READ) && !i.imm_sel;
  endfunction

  function automatic logic [6:0] pack_control(input instr_t i);
    return {i.operation, i.imm_sel, i.opselect};
  endfunction

  function automatic logic [15:0] sign_extend_imm(input logic [12:0] imm13);
    return {{3{imm13[12]}}, imm13};
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-to-decode-to-execute bundle; master is the fetch/control side,
// slave is the decode stage.
interface decode_stage_if;

  logic        enable_dec;
  logic [31:0] instr_in;
  logic        flush;
  logic        stall_out;
  logic        enable_ex;
  logic [6:0]  control_out;
  logic [15:0] imm;
  logic [3:0]  src1_addr;
  logic [3:0]  src2_addr;
  logic [3:0]  dest_addr;
  logic        illegal_instr;
  logic [15:0] stall_count;

  modport master (
    output enable_dec, instr_in, flush,
    input  stall_out, enable_ex, control_out, imm, src1_addr, src2_addr,
           dest_addr, illegal_instr, stall_count
  );

  modport slave (
    input  enable_dec, instr_in, flush,
    output stall_out, enable_ex, control_out, imm, src1_addr, src2_addr,
           dest_addr, illegal_instr, stall_count
  );

endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard comparison between the instruction sitting in execute and
// the newly presented instruction.
module hazard_detect
  import dlx_pkg::*;
(
  input  logic       ex_valid,
  input  logic       ex_load,
  input  logic [3:0] ex_dest,
  input  instr_t     new_instr,
  output logic       hazard
);

  logic src2_used;

  // ARITH_LOGIC with an immediate reads the immediate instead of src2.
  always_comb begin
    src2_used = !((new_instr.opselect == OP_ARITH_LOGIC) && new_instr.imm_sel);
    hazard    = ex_valid && ex_load &&
                ((ex_dest == new_instr.src1) ||
                 (src2_used && (ex_dest == new_instr.src2)));
  end

endmodule

// File: rtl/decode_stage.sv
// DLX decode stage: field decode, immediate sign extension, one-cycle
// load-use stall with a single hold register, flush and illegal detection.
module decode_stage
  import dlx_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  decode_stage_if.slave dec
);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] STALL = 1'b1;

  logic [0:0]  state;
  logic [0:0]  next_state;
  instr_t      hold_instr;
  instr_t      cur_instr;
  instr_t      issue_instr;
  logic        issue;
  logic        capture;
  logic        flag_illegal;
  logic        hazard;

  logic        enable_ex_q;
  logic        ex_load_q;
  logic [6:0]  control_q;
  logic [15:0] imm_q;
  logic [3:0]  src1_q;
  logic [3:0]  src2_q;
  logic [3:0]  dest_q;
  logic        illegal_q;
  logic [15:0] stall_cnt;

  assign cur_instr = decode_fields(dec.instr_in);

  hazard_detect u_hazard_detect (
    .ex_valid  (enable_ex_q),
    .ex_load   (ex_load_q),
    .ex_dest   (dest_q),
    .new_instr (cur_instr),
    .hazard    (hazard)
  );

  // Flush outranks STALL issue, which outranks any new fetch.
  always_comb begin
    issue        = 1'b0;
    issue_instr  = cur_instr;
    capture      = 1'b0;
    flag_illegal = 1'b0;
    next_state   = state;
    if (dec.flush) begin
      next_state = RUN;
    end else if (state == STALL) begin
      issue       = 1'b1;
      issue_instr = hold_instr;
      next_state  = RUN;
    end else if (dec.enable_dec) begin
      if (!is_legal(cur_instr.opselect)) begin
        flag_illegal = 1'b1;
      end else if (hazard) begin
        capture    = 1'b1;
        next_state = STALL;
      end else begin
        issue = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= RUN;
      hold_instr <= '0;
      stall_cnt  <= '0;
    end else begin
      state <= next_state;
      if (dec.flush) begin
        hold_instr <= '0;
      end else if (capture) begin
        hold_instr <= cur_instr;
      end
      if (capture && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end

  // Decoded fields only move on an issue so they hold between issues.
  always_ff @(posedge clock) begin
    if (reset) begin
      enable_ex_q <= 1'b0;
      ex_load_q   <= 1'b0;
      control_q   <= '0;
      imm_q       <= '0;
      src1_q      <= '0;
      src2_q      <= '0;
      dest_q      <= '0;
      illegal_q   <= 1'b0;
    end else begin
      enable_ex_q <= issue;
      illegal_q   <= flag_illegal;
      if (issue) begin
        ex_load_q <= is_load(issue_instr);
        control_q <= pack_control(issue_instr);
        imm_q     <= sign_extend_imm(issue_instr.imm13);
        src1_q    <= issue_instr.src1;
        src2_q    <= issue_instr.src2;
        dest_q    <= issue_instr.dest;
      end
    end
  end

  assign dec.stall_out     = (state == STALL);
  assign dec.enable_ex     = enable_ex_q;
  assign dec.control_out   = control_q;
  assign dec.imm           = imm_q;
  assign dec.src1_addr     = src1_q;
  assign dec.src2_addr     = src2_q;
  assign dec.dest_addr     = dest_q;
  assign dec.illegal_instr = illegal_q;
  assign dec.stall_count   = stall_cnt;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: inputs change on the falling edge and
// outputs are compared on the following falling edge.
module tb_decode_stage;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  decode_stage_if bus ();

  decode_stage dut (
    .clock (clock),
    .reset (reset),
    .dec   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mk(input logic [2:0] opsel, input logic isel,
                                     input logic [2:0] op, input logic [3:0] dst,
                                     input logic [3:0] s1, input logic [3:0] s2,
                                     input logic [12:0] i13);
    return {opsel, isel, op, dst, s1, s2, i13};
  endfunction

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic en, input logic [31:0] instr,
                                input logic fl);
    bus.enable_dec = en;
    bus.instr_in   = instr;
    bus.flush      = fl;
  endtask

  task automatic next_cycle();
    @(negedge clock);
  endtask

  logic [31:0] load5;
  assign load5 = mk(3'b101, 1'b0, 3'b000, 4'd5, 4'd1, 4'd0, 13'h0);

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    apply_stimulus(1'b0, 32'h0, 1'b0);
    repeat (2) next_cycle();

    check_output("rst_enable_ex", bus.enable_ex, 0);
    check_output("rst_stall_out", bus.stall_out, 0);
    check_output("rst_control", bus.control_out, 0);
    check_output("rst_imm", bus.imm, 0);
    check_output("rst_stall_count", bus.stall_count, 0);
    check_output("rst_illegal", bus.illegal_instr, 0);
    reset = 1'b0;

    // Register-register arithmetic, then an idle cycle holding the fields
    apply_stimulus(1'b1, mk(3'b001, 1'b0, 3'b010, 4'd3, 4'd1, 4'd2, 13'h0), 1'b0);
    next_cycle();
    check_output("arith_enable_ex", bus.enable_ex, 1);
    check_output("arith_control", bus.control_out, 7'b010_0_001);
    check_output("arith_src1", bus.src1_addr, 1);
    check_output("arith_src2", bus.src2_addr, 2);
    check_output("arith_dest", bus.dest_addr, 3);
    apply_stimulus(1'b0, 32'h0, 1'b0);
    next_cycle();
    check_output("idle_enable_ex", bus.enable_ex, 0);
    check_output("idle_control_hold", bus.control_out, 7'b010_0_001);
    check_output("idle_dest_hold", bus.dest_addr, 3);

    // Back-to-back immediates: negative arith immediate then a shift
    apply_stimulus(1'b1, mk(3'b001, 1'b1, 3'b000, 4'd1, 4'd2, 4'd3, 13'h1FFF), 1'b0);
    next_cycle();
    check_output("imm_neg_enable_ex", bus.enable_ex, 1);
    check_output("imm_neg_value", bus.imm, 16'hFFFF);
    check_output("imm_neg_control", bus.control_out, 7'b000_1_001);
    apply_stimulus(1'b1, mk(3'b000, 1'b1, 3'b011, 4'd4, 4'd0, 4'd0, 13'h0040), 1'b0);
    next_cycle();
    check_output("imm_pos_enable_ex", bus.enable_ex, 1);
    check_output("imm_pos_value", bus.imm, 16'h0040);
    check_output("shift_control", bus.control_out, 7'b011_1_000);

    // Load r5 followed by a src1 consumer: 1,0,1 on enable_ex
    apply_stimulus(1'b1, load5, 1'b0);
    next_cycle();
    check_output("lu_load_enable_ex", bus.enable_ex, 1);
    check_output("lu_load_dest", bus.dest_addr, 5);
    apply_stimulus(1'b1, mk(3'b001, 1'b0, 3'b000, 4'd6, 4'd5, 4'd2, 13'h0), 1'b0);
    next_cycle();
    check_output("lu_bubble_enable_ex", bus.enable_ex, 0);
    check_output("lu_stall_out", bus.stall_out, 1);
    check_output("lu_stall_count", bus.stall_count, 1);
    next_cycle();
    check_output("lu_issue_enable_ex", bus.enable_ex, 1);
    check_output("lu_issue_src1", bus.src1_addr, 5);
    check_output("lu_issue_dest", bus.dest_addr, 6);
    check_output("lu_stall_cleared", bus.stall_out, 0);
    apply_stimulus(1'b0, 32'h0, 1'b0);
    next_cycle();
    check_output("lu_after_enable_ex", bus.enable_ex, 0);

    // Immediate arith reading r5 only as src2 does not stall
    apply_stimulus(1'b1, load5, 1'b0);
    next_cycle();
    apply_stimulus(1'b1, mk(3'b001, 1'b1, 3'b000, 4'd7, 4'd4, 4'd5, 13'h3), 1'b0);
    next_cycle();
    check_output("nohaz_enable_ex", bus.enable_ex, 1);
    check_output("nohaz_stall_out", bus.stall_out, 0);
    check_output("nohaz_dest", bus.dest_addr, 7);
    check_output("nohaz_stall_count", bus.stall_count, 1);

    // Register-form src2 consumer of r5 does stall
    apply_stimulus(1'b1, load5, 1'b0);
    next_cycle();
    apply_stimulus(1'b1, mk(3'b001, 1'b0, 3'b001, 4'd8, 4'd3, 4'd5, 13'h0), 1'b0);
    next_cycle();
    check_output("src2haz_enable_ex", bus.enable_ex, 0);
    check_output("src2haz_stall_out", bus.stall_out, 1);
    check_output("src2haz_stall_count", bus.stall_count, 2);
    next_cycle();
    check_output("src2haz_issue_dest", bus.dest_addr, 8);
    check_output("src2haz_issue_enable_ex", bus.enable_ex, 1);

    // Flush while stalled drops the held instruction
    apply_stimulus(1'b1, load5, 1'b0);
    next_cycle();
    apply_stimulus(1'b1, mk(3'b001, 1'b0, 3'b000, 4'd9, 4'd5, 4'd2, 13'h0), 1'b0);
    next_cycle();
    check_output("flush_pre_stall_out", bus.stall_out, 1);
    check_output("flush_pre_count", bus.stall_count, 3);
    apply_stimulus(1'b0, 32'h0, 1'b1);
    next_cycle();
    check_output("flush_enable_ex", bus.enable_ex, 0);
    check_output("flush_stall_out", bus.stall_out, 0);
    apply_stimulus(1'b0, 32'h0, 1'b0);
    next_cycle();
    check_output("flush_post_enable_ex", bus.enable_ex, 0);
    check_output("flush_post_dest", bus.dest_addr, 5);

    // Illegal opselect after a load: no issue, no hazard check
    apply_stimulus(1'b1, load5, 1'b0);
    next_cycle();
    apply_stimulus(1'b1, mk(3'b011, 1'b0, 3'b000, 4'd2, 4'd5, 4'd5, 13'h0), 1'b0);
    next_cycle();
    check_output("illegal_pulse", bus.illegal_instr, 1);
    check_output("illegal_enable_ex", bus.enable_ex, 0);
    check_output("illegal_stall_out", bus.stall_out, 0);
    check_output("illegal_count", bus.stall_count, 3);
    apply_stimulus(1'b0, 32'h0, 1'b0);
    next_cycle();
    check_output("illegal_clear", bus.illegal_instr, 0);

    // Saturated counter stays at its ceiling across another hazard
    force dut.stall_cnt = 16'hFFFF;
    #1;
    release dut.stall_cnt;
    check_output("sat_preset", bus.stall_count, 16'hFFFF);
    next_cycle();
    apply_stimulus(1'b1, load5, 1'b0);
    next_cycle();
    apply_stimulus(1'b1, mk(3'b001, 1'b0, 3'b000, 4'd10, 4'd5, 4'd1, 13'h0), 1'b0);
    next_cycle();
    check_output("sat_stall_out", bus.stall_out, 1);
    check_output("sat_count", bus.stall_count, 16'hFFFF);
    next_cycle();
    check_output("sat_issue_dest", bus.dest_addr, 10);

    // Reset during STALL discards the held instruction
    apply_stimulus(1'b1, load5, 1'b0);
    next_cycle();
    apply_stimulus(1'b1, mk(3'b001, 1'b0, 3'b000, 4'd11, 4'd5, 4'd1, 13'h0), 1'b0);
    next_cycle();
    check_output("rststall_pre", bus.stall_out, 1);
    reset = 1'b1;
    apply_stimulus(1'b0, 32'h0, 1'b0);
    next_cycle();
    check_output("rststall_enable_ex", bus.enable_ex, 0);
    check_output("rststall_stall_out", bus.stall_out, 0);
    check_output("rststall_count", bus.stall_count, 0);
    check_output("rststall_dest", bus.dest_addr, 0);
    reset = 1'b0;
    next_cycle();
    check_output("rststall_post_enable_ex", bus.enable_ex, 0);
    check_output("rststall_post_stall_out", bus.stall_out, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
